// File: rtl/bp_cce_pkg.sv
// CCE-local definitions: directory way-group reader FSM states.
package bp_cce_pkg;

  typedef enum logic [1:0] {
    e_IDLE  = 2'd0,
    e_READ  = 2'd1,
    e_DRAIN = 2'd2,
    e_DONE  = 2'd3
  } bp_cce_dir_wg_reader_state_e;

endpackage

// File: rtl/bp_common_pkg.sv
// Shared processor-configuration and coherence-state definitions.
package bp_common_pkg;

  typedef enum logic [2:0] {
    e_COH_I = 3'b000,
    e_COH_S = 3'b001,
    e_COH_E = 3'b010,
    e_COH_F = 3'b011,
    e_COH_O = 3'b100,
    e_COH_M = 3'b110
  } bp_coh_states_e;

  typedef enum logic [1:0] {
    e_bp_inv_cfg         = 2'd0,
    e_bp_single_core_cfg = 2'd1
  } bp_params_e;

  function automatic int bp_num_lce(bp_params_e p);
    case (p)
      e_bp_single_core_cfg: return 2;
      default:              return 4;
    endcase
  endfunction

  function automatic int bp_lce_assoc(bp_params_e p);
    case (p)
      default: return 8;
    endcase
  endfunction

  function automatic int bp_tag_width(bp_params_e p);
    case (p)
      default: return 12;
    endcase
  endfunction

  function automatic int bp_num_way_groups(bp_params_e p);
    case (p)
      default: return 16;
    endcase
  endfunction

endpackage

// File: rtl/bp_cce_dir_tag_compare.sv
// Combinational tag match across one LCE's ways; lowest hitting way wins.
module bp_cce_dir_tag_compare
  import bp_common_pkg::*;
#(
  parameter int assoc_p     = 8,
  parameter int tag_width_p = 12,
  localparam int way_width_lp   = $clog2(assoc_p),
  localparam int state_width_lp = $bits(bp_coh_states_e),
  localparam int entry_width_lp = tag_width_p + state_width_lp
) (
  input  logic [assoc_p*entry_width_lp-1:0] entries_i,
  input  logic [tag_width_p-1:0]            tag_i,
  output logic                              hit_o,
  output logic [way_width_lp-1:0]           way_o,
  output bp_coh_states_e                    state_o,
  output logic                              multi_o
);

  logic [assoc_p-1:0][entry_width_lp-1:0] entry;
  logic [assoc_p-1:0]                     way_hit;

  assign entry = entries_i;

  // per-way match: tag equal and line not invalid
  always_comb begin
    way_hit = '0;
    for (int w = 0; w < assoc_p; w++) begin
      way_hit[w] = (entry[w][entry_width_lp-1 -: tag_width_p] == tag_i)
                && (entry[w][state_width_lp-1:0] != e_COH_I);
    end
  end

  // scan from way 0 upward so the lowest hit is kept; any further hit flags multi
  always_comb begin
    hit_o   = 1'b0;
    way_o   = '0;
    state_o = e_COH_I;
    multi_o = 1'b0;
    for (int w = 0; w < assoc_p; w++) begin
      if (way_hit[w]) begin
        if (hit_o) begin
          multi_o = 1'b1;
        end else begin
          hit_o   = 1'b1;
          way_o   = way_width_lp'(w);
          state_o = bp_coh_states_e'(entry[w][state_width_lp-1:0]);
        end
      end
    end
  end

endmodule

// File: rtl/bp_cce_dir_wg_reader.sv
// Reads one directory way-group row by row and consolidates per-LCE sharer info.
//
// state   | meaning
// e_IDLE  | ready for a request
// e_READ  | issuing one RAM row read per cycle
// e_DRAIN | absorbing data for the last row issued
// e_DONE  | result valid, waiting for sharers_yumi_i
module bp_cce_dir_wg_reader
  import bp_common_pkg::*;
  import bp_cce_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_inv_cfg,
  parameter int lces_per_row_p      = 2,
  localparam int num_lce_p          = bp_num_lce(bp_params_p),
  localparam int lce_assoc_p        = bp_lce_assoc(bp_params_p),
  localparam int tag_width_p        = bp_tag_width(bp_params_p),
  localparam int lce_assoc_width_p  = $clog2(lce_assoc_p),
  localparam int wg_width_lp        = $clog2(bp_num_way_groups(bp_params_p)),
  localparam int rows_lp            = num_lce_p / lces_per_row_p,
  localparam int row_width_lp       = (rows_lp > 1) ? $clog2(rows_lp) : 1,
  localparam int entry_width_lp     = tag_width_p + $bits(bp_coh_states_e),
  localparam int lce_data_width_lp  = lce_assoc_p * entry_width_lp,
  localparam int row_data_width_lp  = lces_per_row_p * lce_data_width_lp
) (
  input  logic                                          clk_i,
  input  logic                                          reset_n_i,
  input  logic                                          v_i,
  output logic                                          ready_o,
  input  logic [wg_width_lp-1:0]                        wg_i,
  input  logic [tag_width_p-1:0]                        tag_i,
  output logic                                          rd_v_o,
  output logic [wg_width_lp+row_width_lp-1:0]           rd_addr_o,
  input  logic [row_data_width_lp-1:0]                  rd_data_i,
  output logic                                          sharers_v_o,
  input  logic                                          sharers_yumi_i,
  output logic [num_lce_p-1:0]                          sharers_hits_o,
  output logic [num_lce_p-1:0][lce_assoc_width_p-1:0]   sharers_ways_o,
  output bp_coh_states_e [num_lce_p-1:0]                sharers_coh_states_o,
  output logic                                          multi_hit_o
);

  localparam logic [row_width_lp-1:0] last_row_lp = row_width_lp'(rows_lp - 1);

  bp_cce_dir_wg_reader_state_e state_r;
  logic [wg_width_lp-1:0]      wg_r;
  logic [tag_width_p-1:0]      tag_r;
  logic                        data_v_r;
  logic [row_width_lp-1:0]     data_row_r;
  logic                        accept;

  logic [lces_per_row_p-1:0]                        cmp_hit;
  logic [lces_per_row_p-1:0][lce_assoc_width_p-1:0] cmp_way;
  bp_coh_states_e [lces_per_row_p-1:0]              cmp_state;
  logic [lces_per_row_p-1:0]                        cmp_multi;

  assign ready_o     = (state_r == e_IDLE);
  assign sharers_v_o = (state_r == e_DONE);
  assign accept      = v_i & ready_o;

  // request sequencing; the row field of rd_addr_o doubles as the row counter
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r   <= e_IDLE;
      wg_r      <= '0;
      tag_r     <= '0;
      rd_v_o    <= 1'b0;
      rd_addr_o <= '0;
    end else begin
      case (state_r)
        e_IDLE: if (v_i) begin
          wg_r      <= wg_i;
          tag_r     <= tag_i;
          rd_v_o    <= 1'b1;
          rd_addr_o <= {wg_i, {row_width_lp{1'b0}}};
          state_r   <= e_READ;
        end
        e_READ: if (rd_addr_o[row_width_lp-1:0] == last_row_lp) begin
          rd_v_o    <= 1'b0;
          rd_addr_o <= '0;
          state_r   <= e_DRAIN;
        end else begin
          rd_addr_o <= {wg_r, rd_addr_o[row_width_lp-1:0] + 1'b1};
        end
        e_DRAIN: state_r <= e_DONE;
        e_DONE:  if (sharers_yumi_i) state_r <= e_IDLE;
        default: state_r <= e_IDLE;
      endcase
    end
  end

  // RAM data lags the strobe by one cycle; reset drops any read in flight
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      data_v_r   <= 1'b0;
      data_row_r <= '0;
    end else begin
      data_v_r   <= rd_v_o;
      data_row_r <= rd_addr_o[row_width_lp-1:0];
    end
  end

  for (genvar j = 0; j < lces_per_row_p; j++) begin : cmp
    bp_cce_dir_tag_compare #(
      .assoc_p     (lce_assoc_p),
      .tag_width_p (tag_width_p)
    ) u_cmp (
      .entries_i (rd_data_i[j*lce_data_width_lp +: lce_data_width_lp]),
      .tag_i     (tag_r),
      .hit_o     (cmp_hit[j]),
      .way_o     (cmp_way[j]),
      .state_o   (cmp_state[j]),
      .multi_o   (cmp_multi[j])
    );
  end

  for (genvar i = 0; i < num_lce_p; i++) begin : lce
    localparam int row_c = i / lces_per_row_p;
    localparam int col_c = i % lces_per_row_p;

    logic                         hit_r;
    logic [lce_assoc_width_p-1:0] way_r;
    bp_coh_states_e               st_r;

    // capture this LCE's result when its row returns; cleared on each new request
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        hit_r <= 1'b0;
        way_r <= '0;
        st_r  <= e_COH_I;
      end else if (accept) begin
        hit_r <= 1'b0;
        way_r <= '0;
        st_r  <= e_COH_I;
      end else if (data_v_r && (data_row_r == row_width_lp'(row_c))) begin
        hit_r <= cmp_hit[col_c];
        way_r <= cmp_way[col_c];
        st_r  <= cmp_state[col_c];
      end
    end

    assign sharers_hits_o[i]       = hit_r;
    assign sharers_ways_o[i]       = way_r;
    assign sharers_coh_states_o[i] = st_r;
  end

  // sticky multi-hit error, only reset clears it
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) multi_hit_o <= 1'b0;
    else if (data_v_r && (|cmp_multi)) multi_hit_o <= 1'b1;
  end

endmodule

// File: tb/tb_bp_cce_dir_wg_reader.sv
// Bench for the directory way-group reader: vector table plus scoreboard queue.
module tb_bp_cce_dir_wg_reader;
  import bp_common_pkg::*;

  localparam int AS = 8;
  localparam int EW = 15;
  localparam int LW = AS * EW;
  localparam int RW = 2 * LW;

  logic clk_i = 1'b0;
  logic reset_n_i = 1'b0;
  logic v_i = 1'b0, v1_i = 1'b0;
  logic yumi = 1'b0, yumi1 = 1'b0;
  logic [3:0]  wg_i = '0;
  logic [11:0] tag_i = '0;

  logic ready_o, rd_v_o, sharers_v_o, multi_hit_o;
  logic [4:0] rd_addr_o;
  logic [RW-1:0] rd_data_i = '0;
  logic [3:0] hits_o;
  logic [3:0][2:0] ways_o;
  bp_coh_states_e [3:0] states_o;

  logic ready1, rd_v1, sv1, multi1;
  logic [4:0] rd_addr1;
  logic [2*RW-1:0] rd_data1 = '0;
  logic [3:0] hits1;
  logic [3:0][2:0] ways1;
  bp_coh_states_e [3:0] states1;

  bp_cce_dir_wg_reader dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_i), .ready_o(ready_o),
    .wg_i(wg_i), .tag_i(tag_i), .rd_v_o(rd_v_o), .rd_addr_o(rd_addr_o),
    .rd_data_i(rd_data_i), .sharers_v_o(sharers_v_o), .sharers_yumi_i(yumi),
    .sharers_hits_o(hits_o), .sharers_ways_o(ways_o),
    .sharers_coh_states_o(states_o), .multi_hit_o(multi_hit_o));

  bp_cce_dir_wg_reader #(.lces_per_row_p(4)) dut1 (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v1_i), .ready_o(ready1),
    .wg_i(wg_i), .tag_i(tag_i), .rd_v_o(rd_v1), .rd_addr_o(rd_addr1),
    .rd_data_i(rd_data1), .sharers_v_o(sv1), .sharers_yumi_i(yumi1),
    .sharers_hits_o(hits1), .sharers_ways_o(ways1),
    .sharers_coh_states_o(states1), .multi_hit_o(multi1));

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // directory RAM model: one-cycle read latency, holds last data otherwise
  logic [RW-1:0] mem [16][2];
  always @(posedge clk_i) begin
    if (rd_v_o) rd_data_i <= mem[rd_addr_o[4:1]][rd_addr_o[0]];
    if (rd_v1)  rd_data1  <= {mem[rd_addr1[4:1]][1], mem[rd_addr1[4:1]][0]};
  end

  int total = 0;
  int bad = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic en; logic [1:0] lce; logic [2:0] way; logic [11:0] tag; logic [2:0] st;
  } ent_t;
  typedef struct packed {
    logic [3:0] hits; logic [3:0][2:0] ways; logic [3:0][2:0] states; logic multi;
  } exp_t;
  typedef struct packed {
    logic [3:0] wg; logic [11:0] tag; ent_t [3:0] ents; exp_t exp;
  } vec_t;

  vec_t vecs[5];
  exp_t sbq[$];
  exp_t last_exp;

  function automatic ent_t e(logic [1:0] l, logic [2:0] w, logic [11:0] t, bp_coh_states_e s);
    return {1'b1, l, w, t, s};
  endfunction

  task automatic load(vec_t v);
    mem[v.wg][0] = '0;
    mem[v.wg][1] = '0;
    for (int k = 0; k < 4; k++) begin
      if (v.ents[k].en) begin
        mem[v.wg][v.ents[k].lce[1]][(int'(v.ents[k].lce[0]) * AS + int'(v.ents[k].way)) * EW +: EW]
          = {v.ents[k].tag, v.ents[k].st};
      end
    end
  endtask

  task automatic issue(vec_t v);
    int n, t0;
    n = 0;
    while (!ready_o && n < 20) begin @(negedge clk_i); n++; end
    chk("ready_before_req", ready_o, 1);
    wg_i = v.wg; tag_i = v.tag; v_i = 1'b1;
    @(posedge clk_i); #1;
    v_i = 1'b0;
    t0 = cyc;
    sbq.push_back(v.exp);
    chk("cleared_on_accept", hits_o, 0);
    @(negedge clk_i);
    chk("rd_row0", {rd_v_o, rd_addr_o}, {1'b1, v.wg, 1'b0});
    @(negedge clk_i);
    chk("rd_row1", {rd_v_o, rd_addr_o}, {1'b1, v.wg, 1'b1});
    @(negedge clk_i);
    chk("rd_idle_drain", {rd_v_o, rd_addr_o}, 0);
    n = 0;
    while (!sharers_v_o && n < 20) begin @(negedge clk_i); n++; end
    chk("sharers_v_latency", cyc - t0, 3);
  endtask

  task automatic check_result();
    if (sbq.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
      return;
    end
    last_exp = sbq.pop_front();
    chk("hits", hits_o, last_exp.hits);
    chk("ways", ways_o, last_exp.ways);
    chk("states", states_o, last_exp.states);
    chk("multi_hit", multi_hit_o, last_exp.multi);
    chk("ready_in_done", ready_o, 0);
  endtask

  task automatic consume();
    yumi = 1'b1;
    @(posedge clk_i); #1;
    yumi = 1'b0;
    chk("ready_after_yumi", ready_o, 1);
    chk("v_after_yumi", sharers_v_o, 0);
  endtask

  initial begin
    int n, t0;
    vecs[0] = '{wg: 4'd3, tag: 12'h1A3,
                ents: {e(2'd2, 3'd5, 12'h1A3, e_COH_M), ent_t'(0), ent_t'(0), ent_t'(0)},
                exp: '{hits: 4'b0100, ways: {3'd0, 3'd5, 3'd0, 3'd0},
                       states: {3'd0, 3'd6, 3'd0, 3'd0}, multi: 1'b0}};
    vecs[1] = '{wg: 4'd5, tag: 12'h055,
                ents: {e(2'd0, 3'd3, 12'h055, e_COH_S), e(2'd3, 3'd0, 12'h055, e_COH_S),
                       e(2'd1, 3'd4, 12'h055, e_COH_I), e(2'd2, 3'd1, 12'h0AA, e_COH_M)},
                exp: '{hits: 4'b1001, ways: {3'd0, 3'd0, 3'd0, 3'd3},
                       states: {3'd1, 3'd0, 3'd0, 3'd1}, multi: 1'b0}};
    vecs[2] = '{wg: 4'd7, tag: 12'h2B0,
                ents: {e(2'd1, 3'd2, 12'h2B0, e_COH_E), e(2'd1, 3'd6, 12'h2B0, e_COH_E),
                       e(2'd0, 3'd0, 12'h2B1, e_COH_M), ent_t'(0)},
                exp: '{hits: 4'b0010, ways: {3'd0, 3'd0, 3'd2, 3'd0},
                       states: {3'd0, 3'd0, 3'd2, 3'd0}, multi: 1'b1}};
    vecs[3] = '{wg: 4'd2, tag: 12'h7FF,
                ents: {e(2'd0, 3'd1, 12'h7FF, e_COH_O), e(2'd1, 3'd7, 12'h7FF, e_COH_F),
                       e(2'd1, 3'd3, 12'h7FF, e_COH_I), e(2'd3, 3'd7, 12'h7FE, e_COH_S)},
                exp: '{hits: 4'b0011, ways: {3'd0, 3'd0, 3'd7, 3'd1},
                       states: {3'd0, 3'd0, 3'd3, 3'd4}, multi: 1'b1}};
    vecs[4] = '{wg: 4'd0, tag: 12'h000,
                ents: {ent_t'(0), ent_t'(0), ent_t'(0), ent_t'(0)},
                exp: '{hits: 4'b0000, ways: '0, states: '0, multi: 1'b1}};
    for (int i = 0; i < 16; i++) begin mem[i][0] = '0; mem[i][1] = '0; end
    for (int i = 0; i < 5; i++) load(vecs[i]);

    repeat (3) @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i);
    chk("rst_ready", ready_o, 1);
    chk("rst_rd", {rd_v_o, rd_addr_o}, 0);
    chk("rst_sharers_v", sharers_v_o, 0);
    chk("rst_outputs", {hits_o, ways_o, states_o}, 0);
    chk("rst_multi", multi_hit_o, 0);

    // single-row configuration: one read, result at t+3
    wg_i = 4'd7; tag_i = 12'h2B0; v1_i = 1'b1;
    @(posedge clk_i); #1;
    v1_i = 1'b0;
    t0 = cyc;
    n = 0;
    while (!sv1 && n < 20) begin @(negedge clk_i); n++; end
    chk("r1_latency", cyc - t0, 2);
    chk("r1_hits", hits1, 4'b0010);
    chk("r1_way1", ways1[1], 3'd2);
    chk("r1_multi", multi1, 1);
    yumi1 = 1'b1;
    @(posedge clk_i); #1;
    yumi1 = 1'b0;
    chk("r1_ready_after_yumi", ready1, 1);

    for (int i = 0; i < 5; i++) begin
      issue(vecs[i]);
      check_result();
      if (i == 1) begin
        // stall: outputs hold, stray request ignored
        wg_i = 4'd9; tag_i = 12'h123; v_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk_i);
          chk("stall_hold", {sharers_v_o, ready_o, hits_o, ways_o, states_o},
              {1'b1, 1'b0, last_exp.hits, last_exp.ways, last_exp.states});
        end
        v_i = 1'b0;
      end
      consume();
    end

    // reset in the middle of a read: row 1 being issued, row 0 data in flight
    wg_i = 4'd5; tag_i = 12'h055; v_i = 1'b1;
    @(posedge clk_i); #1;
    v_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("pre_rst_row1", {rd_v_o, rd_addr_o}, {1'b1, 4'd5, 1'b1});
    reset_n_i = 1'b0;
    #1;
    chk("mid_rst_rd", {rd_v_o, rd_addr_o}, 0);
    chk("mid_rst_outputs", {sharers_v_o, hits_o, ways_o, states_o}, 0);
    chk("mid_rst_multi", multi_hit_o, 0);
    chk("mid_rst_ready", ready_o, 1);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    repeat (4) @(negedge clk_i);
    chk("post_rst_quiet", {sharers_v_o, rd_v_o, hits_o}, 0);
    chk("post_rst_ready", ready_o, 1);

    issue(vecs[0]);
    check_result();
    consume();

    chk("scoreboard_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bp_cce_dir_wg_reader.md
BP_CCE_DIR_WG_READER -- requirements
Module: bp_cce_dir_wg_reader

Interface
REQ-001 Parameters: bp_params_p (default e_bp_inv_cfg) selects the processor config; it supplies num_lce_p, lce_assoc_p and tag_width_p.
REQ-002 Parameter lces_per_row_p, default 2: number of LCE tag sets per directory RAM row; it SHALL divide num_lce_p, and rows_lp = num_lce_p/lces_per_row_p.
REQ-003 Port clk_i, input, 1: the single clock.
REQ-004 Port reset_n_i, input, 1: asynchronous, active-low reset.
REQ-005 Ports v_i/ready_o, input/output, 1/1: read-request handshake.
REQ-006 Ports wg_i, input, way-group index width, plus tag_i, input, tag_width_p: way-group to read and target tag.
REQ-007 Port rd_v_o, output, 1: RAM read strobe.
REQ-008 Port rd_addr_o, output, wg+row width: RAM address {wg, row}.
REQ-009 Port rd_data_i, input, lces_per_row_p*lce_assoc_p*(tag_width_p+state width): RAM data, valid 1 cycle after rd_v_o; each entry is {tag, bp_coh_states_e}.
REQ-010 Ports sharers_v_o/sharers_yumi_i, output/input, 1/1: result handshake.
REQ-011 Ports sharers_hits_o [num_lce_p], sharers_ways_o [num_lce_p][lce_assoc_width_p] and sharers_coh_states_o [num_lce_p], all outputs: the consolidated result.
REQ-012 Port multi_hit_o, output, 1: sticky error flag.

Function
REQ-013 The FSM SHALL have states e_IDLE, e_READ, e_DRAIN and e_DONE.
REQ-014 ready_o SHALL be 1 only in e_IDLE; a handshake (v_i & ready_o) at cycle t SHALL latch wg_i/tag_i, clear all sharers_* outputs to 0 and enter e_READ.
REQ-015 e_READ: rd_v_o=1 with row = 0..rows_lp-1 on cycles t+1..t+rows_lp; the FSM SHALL enter e_DRAIN after the last row is issued.
REQ-016 e_DRAIN: one cycle; it absorbs the data for the last row and then enters e_DONE.
REQ-017 Data arriving for row r SHALL update LCE entries r*lces_per_row_p..(r+1)*lces_per_row_p-1.
REQ-018 A way hits when its entry tag == latched tag and its state != e_COH_I.
REQ-019 For each LCE: hits = OR of way hits; ways = index of the lowest hitting way; states = state of that way. With no hit, ways = 0 and states = e_COH_I.
REQ-020 If more than one way hits within a single LCE, multi_hit_o SHALL be set to 1, the lowest-way result SHALL be used, and multi_hit_o SHALL stay set until reset.
REQ-021 sharers_v_o SHALL be 1 in e_DONE, first at cycle t+rows_lp+2; the outputs SHALL hold stable while sharers_v_o=1 and sharers_yumi_i=0.
REQ-022 On sharers_yumi_i=1 in e_DONE, the FSM SHALL return to e_IDLE next cycle; sharers_* outputs keep their values until the next accept.
REQ-023 sharers_yumi_i outside e_DONE and v_i outside e_IDLE SHALL be ignored, with no state change.
REQ-024 A rows_lp=1 configuration SHALL issue one read, with sharers_v_o at t+3.
REQ-025 rd_v_o SHALL be 0 in all states except e_READ; rd_addr_o SHALL be 0 when rd_v_o=0.

Reset
REQ-026 reset_n_i=0 SHALL asynchronously force: FSM e_IDLE, ready_o=1 once released, rd_v_o=0, sharers_v_o=0, all sharers_* outputs 0 (states e_COH_I), multi_hit_o=0.
REQ-027 A reset asserted mid-read SHALL abandon the read; RAM data returning after reset deasserts SHALL be ignored.

Structure
REQ-028 The FSM state enum bp_cce_dir_wg_reader_state_e SHALL live in bp_cce_pkg; bp_coh_states_e comes from bp_common_pkg.
REQ-029 The per-LCE compare SHALL be one combinational sub-module, bp_cce_dir_tag_compare, instantiated lces_per_row_p times; it takes one LCE's assoc entries plus the tag and returns hit, way, state and multi.
REQ-030 The outputs SHALL connect directly to the GAD stage inputs sharers_v_i, sharers_hits_i, sharers_ways_i and sharers_coh_states_i.

Verification
REQ-031 Config num_lce=4, assoc=8, lces_per_row=2, tag=0x1A3, with LCE2 way5 in M and all other entries invalid -> hits=4'b0100, ways[2]=5, states[2]=M, and sharers_v_o at t+4.
REQ-032 LCE0 way3 in S and LCE3 way0 in S, with LCE1 holding a matching tag in state I -> hits=4'b1001, ways[0]=3, ways[3]=0, hits[1]=0.
REQ-033 LCE1 with way2 and way6 both matching in E -> ways[1]=2, multi_hit_o=1, and multi_hit_o still 1 after the next clean request.
REQ-034 sharers_yumi_i held 0 for 5 cycles -> outputs stable and ready_o=0 throughout; yumi=1 -> ready_o=1 the next cycle; back-to-back requests accepted with no lost cycle beyond that.
REQ-035 reset_n_i pulsed low during e_READ row 1 -> outputs immediately 0, late RAM data ignored, and the next request produces a correct result.
